switch_reader: RTL and testbench

SWITCH_READER -- requirements
Module: switch_reader

---
 rtl/switch_reader_pkg.sv | 32 +++
 rtl/switch_reader_io_debounce.sv | 45 ++++
 rtl/switch_reader.sv | 64 ++++++
 tb/tb_switch_reader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_reader_pkg.sv
// Shared bus address map and read-select decode for the switch/button reader.
package switch_reader_pkg;

    localparam logic [11:0] LED_ADDR  = 12'h060;
    localparam logic [11:0] SW_ADDR   = 12'h070;
    localparam logic [11:0] BTN_ADDR  = 12'h078;

    localparam int SW_WIDTH  = 24;
    localparam int BTN_WIDTH = 5;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_SW,
        SEL_BTN
    } read_sel_e;

    // LED is owned by another block; it decodes to no read data here.
    function automatic read_sel_e decode_addr(input logic en, input logic [11:0] addr);
        read_sel_e sel;
        sel = SEL_NONE;
        if (en) begin
            case (addr)
                SW_ADDR:  sel = SEL_SW;
                BTN_ADDR: sel = SEL_BTN;
                LED_ADDR: sel = SEL_NONE;
                default:  sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/switch_reader_io_debounce.sv
// Two-flop synchronizer plus hold-time debouncer for a group of raw inputs.
module io_debounce #(
    parameter int WIDTH     = 1,
    parameter int DB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] stable_next
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] s2_reg;
    logic [WIDTH-1:0] stable_reg;
    logic [CW-1:0]    cnt_reg;
    logic             done;

    // The whole vector is adopted as sampled at completion, even if it changed mid-count.
    assign done        = (s2_reg != stable_reg) && (cnt_reg == CNT_LAST);
    assign stable_next = done ? s2_reg : stable_reg;
    assign stable      = stable_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg     <= '0;
            s2_reg     <= '0;
            stable_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            s1_reg     <= raw;
            s2_reg     <= s1_reg;
            stable_reg <= stable_next;
            if ((s2_reg == stable_reg) || done) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

endmodule

// File: rtl/switch_reader.sv
// Bus-readable debounced switches and buttons with sticky button-press events.
module switch_reader
    import switch_reader_pkg::*;
#(
    parameter int DB_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_en,
    input  logic [11:0] io_addr,
    input  logic [23:0] device_sw,
    input  logic [4:0]  device_btn,
    output logic [31:0] io_read_data
);

    logic [SW_WIDTH-1:0]  sw_stable;
    logic [SW_WIDTH-1:0]  sw_next_unused;
    logic [BTN_WIDTH-1:0] btn_stable;
    logic [BTN_WIDTH-1:0] btn_stable_next;
    logic [BTN_WIDTH-1:0] btn_rise;
    logic [BTN_WIDTH-1:0] btn_event_reg;
    read_sel_e            sel;

    io_debounce #(.WIDTH(SW_WIDTH), .DB_CYCLES(DB_CYCLES)) u_sw_db (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw         (device_sw),
        .stable      (sw_stable),
        .stable_next (sw_next_unused)
    );

    io_debounce #(.WIDTH(BTN_WIDTH), .DB_CYCLES(DB_CYCLES)) u_btn_db (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw         (device_btn),
        .stable      (btn_stable),
        .stable_next (btn_stable_next)
    );

    assign sel = decode_addr(io_en, io_addr);

    // Looking at the next stable value lets the event land on the same edge as the press.
    assign btn_rise = btn_stable_next & ~btn_stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_event_reg <= '0;
        end else if (sel == SEL_BTN) begin
            btn_event_reg <= btn_rise;
        end else begin
            btn_event_reg <= btn_event_reg | btn_rise;
        end
    end

    always_comb begin
        io_read_data = '0;
        case (sel)
            SEL_SW:  io_read_data = {8'b0, sw_stable};
            SEL_BTN: io_read_data = {19'b0, btn_event_reg, 3'b0, btn_stable};
            default: io_read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_switch_reader.sv
// Self-checking bench for switch_reader with DB_CYCLES = 4.
module tb_switch_reader;
    import switch_reader_pkg::*;

    localparam int DB = 4;

    logic        clk;
    logic        rst_n;
    logic        io_en;
    logic [11:0] io_addr;
    logic [23:0] device_sw;
    logic [4:0]  device_btn;
    logic [31:0] io_read_data;

    int n_checks = 0;
    int n_fail   = 0;

    switch_reader #(.DB_CYCLES(DB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_en        (io_en),
        .io_addr      (io_addr),
        .device_sw    (device_sw),
        .device_btn   (device_btn),
        .io_read_data (io_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw -> 2-stage delay -> adopt once it has differed from
    // the stable value on DB consecutive edges.
    logic [23:0] m_sw_s1, m_sw_s2, m_sw_st;
    logic [4:0]  m_btn_s1, m_btn_s2, m_btn_st, m_ev;
    int          m_sw_run, m_btn_run;

    task automatic model_reset();
        m_sw_s1 = '0; m_sw_s2 = '0; m_sw_st = '0; m_sw_run = 0;
        m_btn_s1 = '0; m_btn_s2 = '0; m_btn_st = '0; m_btn_run = 0;
        m_ev = '0;
    endtask

    task automatic model_step();
        logic [23:0] sw_new;
        logic [4:0]  btn_new;
        bit          rd_clr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rd_clr = io_en && (io_addr == BTN_ADDR);
        sw_new = m_sw_st;
        if (m_sw_s2 != m_sw_st) begin
            m_sw_run++;
            if (m_sw_run == DB) begin
                sw_new = m_sw_s2;
                m_sw_run = 0;
            end
        end else begin
            m_sw_run = 0;
        end
        btn_new = m_btn_st;
        if (m_btn_s2 != m_btn_st) begin
            m_btn_run++;
            if (m_btn_run == DB) begin
                btn_new = m_btn_s2;
                m_btn_run = 0;
            end
        end else begin
            m_btn_run = 0;
        end
        m_ev = (rd_clr ? 5'b0 : m_ev) | (btn_new & ~m_btn_st);
        m_sw_st = sw_new;
        m_btn_st = btn_new;
        m_sw_s2 = m_sw_s1;
        m_sw_s1 = device_sw;
        m_btn_s2 = m_btn_s1;
        m_btn_s1 = device_btn;
    endtask

    function automatic logic [31:0] model_read();
        if (!io_en) return 32'h0;
        if (io_addr == SW_ADDR) return {8'h0, m_sw_st};
        if (io_addr == BTN_ADDR) return {19'h0, m_ev, 3'b0, m_btn_st};
        return 32'h0;
    endfunction

    // Advance one rising edge; returns at the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_rd(input logic en, input logic [11:0] addr);
        io_en = en;
        io_addr = addr;
    endtask

    task automatic chk(input string name, input logic [31:0] exp);
        #1;
        n_checks++;
        if (io_read_data !== exp) begin
            n_fail++;
            $display("FAIL %s: io_read_data=%08h expected=%08h", name, io_read_data, exp);
        end else begin
            $display("ok   %s: io_read_data=%08h", name, io_read_data);
        end
    endtask

    typedef struct {
        string       name;
        logic [23:0] sw;
        logic [4:0]  btn;
        logic        en;
        logic [11:0] addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Edge-by-edge SW visibility after reset, then the idle/foreign decodes.
        vecs[0]  = '{"sw_edge1", 24'hA5A5A5, 5'h0, 1'b1, SW_ADDR, 32'h0};
        vecs[1]  = '{"sw_edge2", 24'hA5A5A5, 5'h0, 1'b1, SW_ADDR, 32'h0};
        vecs[2]  = '{"sw_edge3", 24'hA5A5A5, 5'h0, 1'b1, SW_ADDR, 32'h0};
        vecs[3]  = '{"sw_edge4", 24'hA5A5A5, 5'h0, 1'b1, SW_ADDR, 32'h0};
        vecs[4]  = '{"sw_edge5", 24'hA5A5A5, 5'h0, 1'b1, SW_ADDR, 32'h0};
        vecs[5]  = '{"sw_edge6", 24'hA5A5A5, 5'h0, 1'b1, SW_ADDR, 32'h00A5A5A5};
        vecs[6]  = '{"sw_edge7", 24'hA5A5A5, 5'h0, 1'b1, SW_ADDR, 32'h00A5A5A5};
        vecs[7]  = '{"sw_edge8", 24'hA5A5A5, 5'h0, 1'b1, SW_ADDR, 32'h00A5A5A5};
        vecs[8]  = '{"btn_idle", 24'hA5A5A5, 5'h0, 1'b1, BTN_ADDR, 32'h0};
        vecs[9]  = '{"led_addr", 24'hA5A5A5, 5'h0, 1'b1, LED_ADDR, 32'h0};
        vecs[10] = '{"en_low",   24'hA5A5A5, 5'h0, 1'b0, SW_ADDR, 32'h0};
        vecs[11] = '{"sw_again", 24'hA5A5A5, 5'h0, 1'b1, SW_ADDR, 32'h00A5A5A5};

        rst_n = 1'b0;
        io_en = 1'b0;
        io_addr = '0;
        device_sw = '0;
        device_btn = '0;
        model_reset();
        @(negedge clk);
        hold(2);
        set_rd(1'b1, SW_ADDR);
        chk("rst_sw", 32'h0);
        set_rd(1'b1, BTN_ADDR);
        chk("rst_btn", 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            device_sw = vecs[i].sw;
            device_btn = vecs[i].btn;
            set_rd(vecs[i].en, vecs[i].addr);
            tick();
            chk(vecs[i].name, vecs[i].exp);
        end

        // Short glitch on btn[0] must never be accepted.
        set_rd(1'b1, BTN_ADDR);
        device_btn = 5'b00001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("glitch_hi", 32'h0);
        end
        device_btn = 5'b00000;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("glitch_lo", 32'h0);
        end

        // Held press, read-clear, release.
        set_rd(1'b0, BTN_ADDR);
        device_btn = 5'b00100;
        hold(10);
        set_rd(1'b1, BTN_ADDR);
        chk("press_read1", 32'h00000404);
        tick();
        chk("press_read2", 32'h00000004);
        device_btn = 5'b00000;
        set_rd(1'b0, BTN_ADDR);
        hold(8);
        set_rd(1'b1, BTN_ADDR);
        chk("press_release", 32'h0);
        tick();

        // Debounced rise on the same edge as a read-clear: set wins.
        set_rd(1'b0, BTN_ADDR);
        device_btn = 5'b00010;
        hold(5);
        set_rd(1'b1, BTN_ADDR);
        chk("collide_pre", 32'h0);
        tick();
        chk("collide_post", 32'h00000202);
        set_rd(1'b0, BTN_ADDR);
        device_btn = 5'b00000;
        hold(8);
        set_rd(1'b1, BTN_ADDR);
        chk("collide_sticky", 32'h00000200);
        tick();
        chk("collide_cleared", 32'h0);

        // Foreign address and idle bus leave events alone.
        set_rd(1'b0, BTN_ADDR);
        device_btn = 5'b01000;
        hold(8);
        set_rd(1'b1, LED_ADDR);
        chk("noside_led", 32'h0);
        tick();
        set_rd(1'b0, BTN_ADDR);
        chk("noside_idle", 32'h0);
        tick();
        set_rd(1'b1, 12'h071);
        chk("noside_other", 32'h0);
        tick();
        set_rd(1'b1, BTN_ADDR);
        chk("noside_btn", 32'h00000808);
        tick();
        device_btn = 5'b00000;
        set_rd(1'b0, BTN_ADDR);
        hold(8);

        // Reset mid-debounce, inputs held across release.
        set_rd(1'b1, SW_ADDR);
        device_sw = 24'h123456;
        device_btn = 5'b10000;
        hold(2);
        rst_n = 1'b0;
        model_reset();
        chk("midrst_sw", 32'h0);
        hold(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("postrst_edge%0d", k), (k < 6) ? 32'h0 : 32'h00123456);
        end
        set_rd(1'b1, BTN_ADDR);
        chk("postrst_btn", 32'h00001010);
        tick();

        // Randomized traffic against the model, with one reset pulse.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                rst_n = 1'b0;
                model_reset();
            end
            if (i == 302) rst_n = 1'b1;
            if ($urandom_range(0, 7) == 0) device_sw = 24'($urandom);
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 5) == 0) device_btn[b] = ~device_btn[b];
            end
            io_en = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: io_addr = SW_ADDR;
                1: io_addr = BTN_ADDR;
                2: io_addr = LED_ADDR;
                default: io_addr = 12'($urandom_range(0, 4095));
            endcase
            chk($sformatf("rand%0d", i), model_read());
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
